// File: rtl/psum_acc_spad_pkg.sv
// Shared definitions for the partial-sum scratchpad: request opcodes and
// the clear sequencer states.
package psum_acc_spad_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ACC   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/psum_acc_spad_if.sv
// Request/response bundle of the partial-sum scratchpad.
interface psum_acc_spad_if
    import psum_acc_spad_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic                     req_valid;
    logic                     req_ready;
    op_e                      req_op;
    logic [ADDR_W-1:0]        req_addr;
    logic signed [DATA_W-1:0] req_data;
    logic                     rd_valid;
    logic signed [DATA_W-1:0] rd_data;
    logic                     busy;
    logic                     err;

    modport master (
        output req_valid, req_op, req_addr, req_data,
        input  req_ready, rd_valid, rd_data, busy, err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data,
        output req_ready, rd_valid, rd_data, busy, err
    );
endinterface

// File: rtl/psum_acc_spad_sat_add.sv
// Signed adder with optional saturation to the DATA_W range (SAT=1) or
// plain two's-complement wrap (SAT=0).
module sat_add #(
    parameter int DATA_W = 16,
    parameter int SAT    = 1
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y
);
    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    // Overflow shows up as disagreement between the guard bit and the sign bit.
    function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [DATA_W:0] s);
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? MIN_V : MAX_V;
        end
        return s[DATA_W-1:0];
    endfunction

    logic signed [DATA_W:0] sum_w;

    assign sum_w = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    assign y     = (SAT != 0) ? sat_fn(sum_w) : sum_w[DATA_W-1:0];
endmodule

// File: rtl/psum_acc_spad.sv
// Partial-sum scratchpad: read/write/accumulate on a register array with a
// 2-stage accumulate pipeline, result forwarding and a sequential clear-all.
module psum_acc_spad
    import psum_acc_spad_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 24,
    parameter int ADDR_W = 5,
    parameter int SAT    = 1
) (
    input logic            clk,
    input logic            reset,
    psum_acc_spad_if.slave bus
);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        clr_idx_q, clr_idx_d;
    logic                     clearing, accept, in_range;
    logic                     rd_fire, wr_fire, acc_fire, clr_fire;
    logic                     vld_p1;
    logic [ADDR_W-1:0]        addr_p1;
    logic signed [DATA_W-1:0] addend_p1, old_p1, sum_p1;
    logic signed [DATA_W-1:0] mem [DEPTH];

    assign clearing      = (state_q == ST_CLEAR);
    assign bus.busy      = clearing;
    assign bus.req_ready = !clearing;
    assign accept        = bus.req_valid && !clearing && !reset;
    assign in_range      = ({1'b0, bus.req_addr} < DEPTH_L);
    assign rd_fire       = accept && (bus.req_op == OP_READ);
    assign wr_fire       = accept && (bus.req_op == OP_WRITE) && in_range;
    assign acc_fire      = accept && (bus.req_op == OP_ACC) && in_range;
    assign clr_fire      = accept && (bus.req_op == OP_CLEAR);

    // Reset lands in CLEAR so memory is zeroed before first use.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_fire) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_idx_q == LAST) state_d = ST_IDLE;
                else                   clr_idx_d = clr_idx_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 1 -> 2: capture accumulate address and addend at acceptance.
    always_ff @(posedge clk) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= acc_fire;
    end

    always_ff @(posedge clk) begin
        if (acc_fire) begin
            addr_p1   <= bus.req_addr;
            addend_p1 <= bus.req_data;
        end
    end

    assign old_p1 = mem[addr_p1];

    sat_add #(
        .DATA_W(DATA_W),
        .SAT   (SAT)
    ) u_sat_add (
        .a(old_p1),
        .b(addend_p1),
        .y(sum_p1)
    );

    // Later assignments take priority: a same-edge write beats the stage-2 result.
    always_ff @(posedge clk) begin
        if (vld_p1 && !reset) mem[addr_p1]       <= sum_p1;
        if (wr_fire)          mem[bus.req_addr]  <= bus.req_data;
        if (clearing)         mem[clr_idx_q]     <= '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.err      <= 1'b0;
        end else begin
            bus.rd_valid <= rd_fire;
            bus.err      <= accept && (bus.req_op != OP_CLEAR) && !in_range;
            if (rd_fire) begin
                if (!in_range)                               bus.rd_data <= '0;
                else if (vld_p1 && addr_p1 == bus.req_addr)  bus.rd_data <= sum_p1;
                else                                         bus.rd_data <= mem[bus.req_addr];
            end
        end
    end
endmodule

// File: doc/psum_acc_spad.md
PSUM_ACC_SPAD -- requirements
Module: psum_acc_spad

Interface
REQ-001 Parameter DATA_W, default 16, psum entry width in bits.
REQ-002 Parameter DEPTH, default 24, number of entries.
REQ-003 Parameter ADDR_W, default 5, address width; DEPTH SHALL be at most 2**ADDR_W.
REQ-004 Parameter SAT, default 1; 1 selects signed saturating accumulate, 0 selects two's-complement wrap.
REQ-005 clk  in  1  single clock; all state SHALL change on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block accepts a request this cycle.
REQ-009 req_op  in  2  opcode: 00 read, 01 write, 10 accumulate, 11 clear-all.
REQ-010 req_addr  in  ADDR_W  entry address.
REQ-011 req_data  in  DATA_W  write data or accumulate addend, signed.
REQ-012 rd_valid  out  1  one-cycle pulse qualifying rd_data.
REQ-013 rd_data  out  DATA_W  read result.
REQ-014 busy  out  1  clear sequence in progress.
REQ-015 err  out  1  one-cycle pulse when the accepted request addresses an entry at or above DEPTH.

Function
REQ-016 A request SHALL be accepted in any cycle where req_valid and req_ready are both 1; req_ready SHALL equal not busy.
REQ-017 Read: rd_valid SHALL be 1 and rd_data SHALL hold the entry value in the cycle after acceptance (latency 1).
REQ-018 Write: the entry SHALL take req_data at the acceptance edge; a read accepted the following cycle SHALL return the new value.
REQ-019 Accumulate SHALL use a 2-stage pipeline: stage 1 registers addr/addend at acceptance; stage 2 computes old+addend and writes the entry at the next edge.
REQ-020 With SAT=1, the sum SHALL clamp to +(2**(DATA_W-1)-1) or -(2**(DATA_W-1)); with SAT=0 it SHALL wrap modulo 2**DATA_W.
REQ-021 When stage 2 holds a pending result for address A, any read or accumulate of A that uses the old value in that cycle SHALL take the forwarded pending result instead of memory.
REQ-022 A write to A accepted while stage 2 writes A SHALL win; the entry SHALL hold the write data.
REQ-023 Back-to-back accumulates to one address SHALL be accepted every cycle with no lost addend.
REQ-024 Clear-all SHALL move the FSM IDLE->CLEAR; CLEAR SHALL zero one entry per cycle from 0 to DEPTH-1, then return to IDLE; busy SHALL be 1 throughout CLEAR (DEPTH cycles).
REQ-025 A pending stage-2 accumulate SHALL complete before the CLEAR step zeroes that entry, so no stale value survives a clear.
REQ-026 An out-of-range request SHALL be accepted, SHALL NOT modify memory, SHALL pulse err the next cycle, and a read SHALL return rd_data=0 with rd_valid=1.

Reset
REQ-027 While reset is high: rd_valid=0, rd_data=0, err=0, and the pipeline stage SHALL be invalidated, discarding any pending accumulate.
REQ-028 The cycle after reset deasserts, the FSM SHALL be in CLEAR at entry 0 with busy=1, so memory reads zero once busy falls.
REQ-029 Reset asserted during CLEAR SHALL restart the clear from entry 0.

Structure
REQ-030 Opcode constants and FSM state encodings SHALL be in the shared PE package with the other spad definitions.
REQ-031 The saturating adder SHALL be a separate sub-module, sat_add, parametrised by DATA_W and SAT.
REQ-032 Storage SHALL be a plain register array of DEPTH x DATA_W.

Verification
REQ-033 Reset, then wait for busy=0; read addresses 0..23 -> every rd_data=0, busy high for exactly 24 cycles.
REQ-034 Write 0x0010 to addr 3, then read addr 3 next cycle -> rd_data=0x0010 one cycle later.
REQ-035 Five back-to-back accumulates of +100 to addr 7 (initially 0), then read addr 7 -> 500.
REQ-036 SAT=1: write 0x7FF0 to addr 2, accumulate +0x0100 -> read 0x7FFF; SAT=0 build -> 0x80F0.
REQ-037 Read addr 30 -> rd_valid=1, rd_data=0, err pulses once; memory unchanged.
REQ-038 Accumulate +5 to addr 1, assert reset in the next cycle, release, wait for busy=0 -> addr 1 reads 0 and rd_valid stays 0 during reset.
